// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT front-end: sample geometry and arbiter state encoding.
package fft_pkg;

    localparam int FFT_N    = 16;
    localparam int SAMPLE_W = 16;

    typedef struct packed {
        logic signed [SAMPLE_W-1:0] re;
        logic signed [SAMPLE_W-1:0] im;
    } cplx_t;

    typedef enum logic {
        IDLE,
        GRANT
    } arb_state_t;

endpackage

// File: rtl/fft_tag_fifo.sv
// In-order channel tag FIFO; a push is accepted while full when a pop happens in the same cycle.
module fft_tag_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    // Pointers rely on DEPTH being a power of two so they wrap naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/fft_frame_arbiter.sv
// Frame-granular round-robin arbiter sharing one FFT core among NUM_CH streams, with in-order result tagging.
// Optional sticky protocol-error output err_flag is enabled by defining FFT_ARB_ERR_EN.
module fft_frame_arbiter
    import fft_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int CH_W      = 2,
    parameter int FRAME_LEN = FFT_N,
    parameter int TAG_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_CH-1:0]          ch_req,
    input  logic [NUM_CH-1:0]          ch_push,
    input  logic [NUM_CH*SAMPLE_W-1:0] ch_real,
    input  logic [NUM_CH*SAMPLE_W-1:0] ch_imag,
    output logic [NUM_CH-1:0]          ch_stall,
    output logic                       fft_push,
    output logic [SAMPLE_W-1:0]        fft_real,
    output logic [SAMPLE_W-1:0]        fft_imag,
    input  logic                       fft_stall,
    input  logic                       fft_out_push,
    input  logic [SAMPLE_W-1:0]        fft_out_real,
    input  logic [SAMPLE_W-1:0]        fft_out_imag,
    output logic                       fft_out_stall,
    output logic                       out_push,
    output logic [SAMPLE_W-1:0]        out_real,
    output logic [SAMPLE_W-1:0]        out_imag,
    output logic [CH_W-1:0]            out_ch,
    output logic                       out_last,
    input  logic                       out_stall
`ifdef FFT_ARB_ERR_EN
    ,
    output logic                       err_flag
`endif
);

    localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    arb_state_t       state;
    logic [CH_W-1:0]  grant;
    logic [CH_W-1:0]  last_grant;
    logic [CH_W-1:0]  pick;
    logic [CNT_W-1:0] in_cnt;
    logic [CNT_W-1:0] out_cnt;
    logic             any_req;
    logic             tag_push;
    logic             tag_pop;
    logic             tag_full;
    logic             tag_empty;
    logic [CH_W-1:0]  tag_head;
    cplx_t            in_sample;

    assign any_req = |ch_req;

    // First requester strictly after last_grant, wrapping around.
    always_comb begin
        logic found;
        pick  = '0;
        found = 1'b0;
        for (int off = 1; off <= NUM_CH; off++) begin
            int idx;
            idx = (int'(last_grant) + off) % NUM_CH;
            if (!found && ch_req[idx]) begin
                pick  = CH_W'(idx);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        in_sample.re = ch_real[SAMPLE_W*int'(grant) +: SAMPLE_W];
        in_sample.im = ch_imag[SAMPLE_W*int'(grant) +: SAMPLE_W];
    end

    assign fft_real = in_sample.re;
    assign fft_imag = in_sample.im;

    always_comb begin
        ch_stall = '1;
        fft_push = 1'b0;
        if (state == GRANT) begin
            ch_stall[grant] = fft_stall;
            fft_push        = ch_push[grant] & ~fft_stall;
        end
    end

    // A pop in the same cycle frees a slot, so a full FIFO can still take the new tag.
    assign tag_pop  = out_last & ~tag_empty;
    assign tag_push = (state == IDLE) & any_req & (~tag_full | tag_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= CH_W'(NUM_CH-1);
            in_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (tag_push) begin
                        grant <= pick;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (fft_push) begin
                        if (in_cnt == CNT_W'(FRAME_LEN-1)) begin
                            in_cnt     <= '0;
                            last_grant <= grant;
                            state      <= IDLE;
                        end else begin
                            in_cnt <= in_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign out_push      = fft_out_push;
    assign out_real      = fft_out_real;
    assign out_imag      = fft_out_imag;
    assign fft_out_stall = out_stall;
    assign out_ch        = tag_empty ? '0 : tag_head;
    assign out_last      = (out_cnt == CNT_W'(FRAME_LEN-1)) & fft_out_push;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            out_cnt <= '0;
        else if (fft_out_push)
            out_cnt <= out_last ? '0 : out_cnt + 1'b1;
    end

    fft_tag_fifo #(
        .WIDTH (CH_W),
        .DEPTH (TAG_DEPTH)
    ) u_tags (
        .clk   (clk),
        .reset (reset),
        .push  (tag_push),
        .din   (pick),
        .pop   (tag_pop),
        .head  (tag_head),
        .full  (tag_full),
        .empty (tag_empty)
    );

`ifdef FFT_ARB_ERR_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            err_flag <= 1'b0;
        else if ((|(ch_push & ch_stall)) || (fft_out_push && tag_empty))
            err_flag <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_fft_frame_arbiter.sv
// Directed self-checking bench for fft_frame_arbiter (4 channels, 16-sample frames, 4-deep tag FIFO).
module tb_fft_frame_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  ch_req;
    logic [3:0]  ch_push;
    logic [63:0] ch_real;
    logic [63:0] ch_imag;
    logic [3:0]  ch_stall;
    logic        fft_push;
    logic [15:0] fft_real;
    logic [15:0] fft_imag;
    logic        fft_stall;
    logic        fft_out_push;
    logic [15:0] fft_out_real;
    logic [15:0] fft_out_imag;
    logic        fft_out_stall;
    logic        out_push;
    logic [15:0] out_real;
    logic [15:0] out_imag;
    logic [1:0]  out_ch;
    logic        out_last;
    logic        out_stall;
`ifdef FFT_ARB_ERR_EN
    logic        err_flag;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fft_frame_arbiter dut (
        .clk           (clk),
        .reset         (rst_n),
        .ch_req        (ch_req),
        .ch_push       (ch_push),
        .ch_real       (ch_real),
        .ch_imag       (ch_imag),
        .ch_stall      (ch_stall),
        .fft_push      (fft_push),
        .fft_real      (fft_real),
        .fft_imag      (fft_imag),
        .fft_stall     (fft_stall),
        .fft_out_push  (fft_out_push),
        .fft_out_real  (fft_out_real),
        .fft_out_imag  (fft_out_imag),
        .fft_out_stall (fft_out_stall),
        .out_push      (out_push),
        .out_real      (out_real),
        .out_imag      (out_imag),
        .out_ch        (out_ch),
        .out_last      (out_last),
        .out_stall     (out_stall)
`ifdef FFT_ARB_ERR_EN
        ,
        .err_flag      (err_flag)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        ch_req       = '0;
        ch_push      = '0;
        ch_real      = '0;
        ch_imag      = '0;
        fft_stall    = 1'b0;
        fft_out_push = 1'b0;
        fft_out_real = '0;
        fft_out_imag = '0;
        out_stall    = 1'b0;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset;
        rst_n   = 1'b0;
        clear_inputs();
        ch_req  = 4'hF;
        ch_push = 4'hF;
        repeat (2) tick();
        checks++;
        if (ch_stall !== 4'hF) begin
            errors++;
            $display("[TB] FAIL reset_ch_stall: got %b expected 1111", ch_stall);
        end
        checks++;
        if (fft_push !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_fft_push: got %b expected 0", fft_push);
        end
        checks++;
        if (out_push !== 1'b0 || fft_out_stall !== 1'b0 || out_last !== 1'b0 || out_ch !== 2'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got push=%b ostall=%b last=%b ch=%0d expected 0 0 0 0",
                     out_push, fft_out_stall, out_last, out_ch);
        end
`ifdef FFT_ARB_ERR_EN
        checks++;
        if (err_flag !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_err_flag: got %b expected 0", err_flag);
        end
`endif
        rst_n = 1'b1;
        clear_inputs();
    endtask

    task automatic test_reset_mid_frame;
        do_reset();
        ch_req  = 4'b0010;
        tick();
        ch_push = 4'hF;
        for (int c = 0; c < 4; c++) ch_real[16*c +: 16] = 16'(c * 256 + 5);
        #1;
        checks++;
        if (ch_stall !== 4'b1101 || fft_push !== 1'b1 || fft_real !== 16'h0105) begin
            errors++;
            $display("[TB] FAIL t1_grant_ch1: got stall=%b push=%b real=%h expected 1101 1 0105",
                     ch_stall, fft_push, fft_real);
        end
        repeat (7) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (ch_stall !== 4'hF || fft_push !== 1'b0 || out_push !== 1'b0) begin
            errors++;
            $display("[TB] FAIL t1_reset_immediate: got stall=%b push=%b opush=%b expected 1111 0 0",
                     ch_stall, fft_push, out_push);
        end
        tick();
        rst_n  = 1'b1;
        ch_req = 4'hF;
        tick();
        checks++;
        if (ch_stall !== 4'b1110 || fft_real !== 16'h0005) begin
            errors++;
            $display("[TB] FAIL t1_restart_ch0: got stall=%b real=%h expected 1110 0005", ch_stall, fft_real);
        end
        repeat (15) tick();
        checks++;
        if (ch_stall !== 4'b1110) begin
            errors++;
            $display("[TB] FAIL t1_in_cnt_cleared: got stall=%b after 15 accepts expected 1110", ch_stall);
        end
        tick();
        checks++;
        if (ch_stall !== 4'hF) begin
            errors++;
            $display("[TB] FAIL t1_frame_end: got stall=%b after 16 accepts expected 1111", ch_stall);
        end
    endtask

    task automatic test_single_channel;
        logic [15:0] exp_re;
        logic [15:0] exp_im;
        do_reset();
        ch_req = 4'b0100;
        #1;
        checks++;
        if (ch_stall !== 4'hF) begin
            errors++;
            $display("[TB] FAIL t2_grant_latency: got stall=%b before edge expected 1111", ch_stall);
        end
        tick();
        ch_req = 4'b0000;
        for (int k = 0; k < 16; k++) begin
            exp_re  = 16'(k);
            exp_im  = 16'(-k);
            ch_push = 4'b0100;
            ch_real[47:32] = exp_re;
            ch_imag[47:32] = exp_im;
            #1;
            checks++;
            if (fft_push !== 1'b1 || fft_real !== exp_re || fft_imag !== exp_im) begin
                errors++;
                $display("[TB] FAIL t2_sample_%0d: got push=%b re=%h im=%h expected 1 %h %h",
                         k, fft_push, fft_real, fft_imag, exp_re, exp_im);
            end
            tick();
        end
        checks++;
        if (ch_stall !== 4'hF || fft_push !== 1'b0) begin
            errors++;
            $display("[TB] FAIL t2_back_to_idle: got stall=%b push=%b expected 1111 0", ch_stall, fft_push);
        end
        tick();
        checks++;
        if (ch_stall !== 4'hF) begin
            errors++;
            $display("[TB] FAIL t2_no_regrant: got stall=%b expected 1111", ch_stall);
        end
    endtask

    task automatic test_round_robin;
        int          exp_ch;
        logic [3:0]  exp_stall;
        logic [15:0] exp_re;
        logic [15:0] exp_ore;
        do_reset();
        ch_req  = 4'hF;
        ch_push = 4'hF;
        for (int f = 0; f < 8; f++) begin
            exp_ch    = f % 4;
            exp_stall = ~(4'b0001 << exp_ch);
            #1;
            checks++;
            if (ch_stall !== 4'hF) begin
                errors++;
                $display("[TB] FAIL t3_bubble_%0d: got stall=%b expected 1111", f, ch_stall);
            end
            tick();
            checks++;
            if (ch_stall !== exp_stall) begin
                errors++;
                $display("[TB] FAIL t3_grant_%0d: got stall=%b expected %b", f, ch_stall, exp_stall);
            end
            for (int k = 0; k < 16; k++) begin
                for (int c = 0; c < 4; c++) ch_real[16*c +: 16] = 16'(c * 256 + k);
                exp_re       = 16'(exp_ch * 256 + k);
                exp_ore      = 16'(f * 16 + k);
                fft_out_push = 1'b1;
                fft_out_real = exp_ore;
                #1;
                checks++;
                if (fft_real !== exp_re || out_ch !== 2'(exp_ch) || out_last !== (k == 15)
                    || out_push !== 1'b1 || out_real !== exp_ore) begin
                    errors++;
                    $display("[TB] FAIL t3_f%0d_s%0d: got re=%h ch=%0d last=%b opush=%b ore=%h expected %h %0d %b 1 %h",
                             f, k, fft_real, out_ch, out_last, out_push, out_real,
                             exp_re, exp_ch, (k == 15), exp_ore);
                end
                tick();
            end
            fft_out_push = 1'b0;
        end
    endtask

    task automatic test_stall;
        int idx = 0;
        int acc = 0;
        do_reset();
        ch_req = 4'b0001;
        tick();
        ch_req = 4'b0000;
        for (int c = 0; c < 64 && acc < 16; c++) begin
            fft_stall      = (c % 2 == 0);
            ch_push        = 4'b0011;
            ch_real[15:0]  = 16'(idx);
            ch_real[31:16] = 16'hDEAD;
            #1;
            checks++;
            if (ch_stall[0] !== fft_stall || fft_push !== !fft_stall) begin
                errors++;
                $display("[TB] FAIL t4_cycle_%0d: got stall0=%b push=%b expected %b %b",
                         c, ch_stall[0], fft_push, fft_stall, !fft_stall);
            end
            if (fft_push === 1'b1) begin
                acc++;
                checks++;
                if (fft_real !== 16'(idx)) begin
                    errors++;
                    $display("[TB] FAIL t4_data_%0d: got %h expected %h", c, fft_real, 16'(idx));
                end
            end
            if (ch_stall[0] === 1'b0) idx++;
            tick();
        end
        fft_stall = 1'b0;
        ch_push   = 4'b0000;
        #1;
        checks++;
        if (acc !== 16 || ch_stall !== 4'hF) begin
            errors++;
            $display("[TB] FAIL t4_accept_count: got accepts=%0d stall=%b expected 16 1111", acc, ch_stall);
        end
    endtask

    task automatic test_fifo_full;
        do_reset();
        out_stall = 1'b1;
        #1;
        checks++;
        if (fft_out_stall !== 1'b1) begin
            errors++;
            $display("[TB] FAIL t5_out_stall_pass: got %b expected 1", fft_out_stall);
        end
        ch_req  = 4'hF;
        ch_push = 4'hF;
        for (int f = 0; f < 4; f++) begin
            tick();
            repeat (16) tick();
        end
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (ch_stall !== 4'hF) begin
                errors++;
                $display("[TB] FAIL t5_blocked_%0d: got stall=%b expected 1111", c, ch_stall);
            end
            tick();
        end
        checks++;
        if (dut.u_tags.count !== 3'd4) begin
            errors++;
            $display("[TB] FAIL t5_full_count: got %0d expected 4", dut.u_tags.count);
        end
        out_stall    = 1'b0;
        fft_out_push = 1'b1;
        for (int k = 0; k < 16; k++) begin
            #1;
            checks++;
            if (out_ch !== 2'd0 || out_last !== (k == 15) || (k < 15 && ch_stall !== 4'hF)) begin
                errors++;
                $display("[TB] FAIL t5_drain_%0d: got ch=%0d last=%b stall=%b expected 0 %b 1111",
                         k, out_ch, out_last, ch_stall, (k == 15));
            end
            tick();
        end
        fft_out_push = 1'b0;
        #1;
        checks++;
        if (ch_stall !== 4'b1110 || dut.u_tags.count !== 3'd4 || out_ch !== 2'd1) begin
            errors++;
            $display("[TB] FAIL t5_push_pop_same_cycle: got stall=%b count=%0d head=%0d expected 1110 4 1",
                     ch_stall, dut.u_tags.count, out_ch);
        end
    endtask

    task automatic test_empty_tag;
        do_reset();
        fft_out_push = 1'b1;
        fft_out_real = 16'h1234;
        fft_out_imag = 16'hFEDC;
        #1;
        checks++;
        if (out_push !== 1'b1 || out_real !== 16'h1234 || out_imag !== 16'hFEDC || out_ch !== 2'd0) begin
            errors++;
            $display("[TB] FAIL empty_tag_pass: got push=%b re=%h im=%h ch=%0d expected 1 1234 fedc 0",
                     out_push, out_real, out_imag, out_ch);
        end
        tick();
        fft_out_push = 1'b0;
`ifdef FFT_ARB_ERR_EN
        checks++;
        if (err_flag !== 1'b1) begin
            errors++;
            $display("[TB] FAIL empty_tag_err: got %b expected 1", err_flag);
        end
`endif
    endtask

`ifdef FFT_ARB_ERR_EN
    task automatic test_err_flag;
        do_reset();
        ch_req = 4'b0001;
        tick();
        ch_req         = 4'b0000;
        ch_push        = 4'b0011;
        ch_real[15:0]  = 16'h0AAA;
        ch_real[31:16] = 16'h0BBB;
        #1;
        checks++;
        if (fft_real !== 16'h0AAA || err_flag !== 1'b0) begin
            errors++;
            $display("[TB] FAIL t6_before: got re=%h err=%b expected 0aaa 0", fft_real, err_flag);
        end
        tick();
        checks++;
        if (err_flag !== 1'b1) begin
            errors++;
            $display("[TB] FAIL t6_set: got %b expected 1", err_flag);
        end
        ch_push = 4'b0001;
        repeat (3) tick();
        checks++;
        if (err_flag !== 1'b1 || fft_real !== 16'h0AAA) begin
            errors++;
            $display("[TB] FAIL t6_sticky: got err=%b re=%h expected 1 0aaa", err_flag, fft_real);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (err_flag !== 1'b0) begin
            errors++;
            $display("[TB] FAIL t6_reset_clear: got %b expected 0", err_flag);
        end
        rst_n = 1'b1;
    endtask
`endif

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_reset_mid_frame();
        test_single_channel();
        test_round_robin();
        test_stall();
        test_fifo_full();
        test_empty_tag();
`ifdef FFT_ARB_ERR_EN
        test_err_flag();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
